// File: rtl/imem_responder.sv
// Instruction-memory responder: single outstanding word fetch with a fixed access delay.
// Optional misalignment faulting is enabled by defining IMEM_ALIGN_CHECK_EN.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);

    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] latched_addr;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] rd_addr;
    logic        rd_fault;

    // With zero wait cycles the read happens on the accepting edge, so use the live address.
    assign rd_addr = (state == IDLE) ? req_addr : latched_addr;

`ifdef IMEM_ALIGN_CHECK_EN
    assign rd_fault = (rd_addr >= ADDR_LIMIT) || (rd_addr[1:0] != 2'b00);
`else
    assign rd_fault = (rd_addr >= ADDR_LIMIT);
`endif

    assign req_ready = (state == IDLE);

    // Full 32-bit range compare so high address bits never alias into the array.
    always_ff @(posedge clk) begin
        if (prog_we && (prog_addr < ADDR_LIMIT)) begin
            mem[prog_addr[AW+1:2]] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            latched_addr <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_instr    <= 32'h0;
            rsp_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        latched_addr <= req_addr;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= rd_fault;
                            rsp_instr <= rd_fault ? NOP_INSTR : mem[rd_addr[AW+1:2]];
                        end else begin
                            cnt   <= 4'(WAIT_CYCLES);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= rd_fault;
                        rsp_instr <= rd_fault ? NOP_INSTR : mem[rd_addr[AW+1:2]];
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=0 instance.
module tb_imem_responder;

    localparam int unsigned WAITC = 1;

    logic        clk;
    logic        reset;
    logic        req_valid, rsp_ready;
    logic [31:0] req_addr;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_instr;
    logic        prog_we;
    logic [31:0] prog_addr, prog_wdata;

    logic        w0_req_valid, w0_rsp_ready;
    logic [31:0] w0_req_addr;
    logic        w0_req_ready, w0_rsp_valid, w0_rsp_fault;
    logic [31:0] w0_rsp_instr;

    int checks   = 0;
    int failures = 0;

    imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITC)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    imem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(w0_req_valid), .req_addr(w0_req_addr), .req_ready(w0_req_ready),
        .rsp_valid(w0_rsp_valid), .rsp_ready(w0_rsp_ready), .rsp_instr(w0_rsp_instr), .rsp_fault(w0_rsp_fault),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Optional write to the fetched word in the cycle after acceptance.
    task automatic fetch(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         output logic [31:0] instr, output logic fault, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        if (wr) begin prog_we = 1'b1; prog_addr = a; prog_wdata = wd; end
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); prog_we = 1'b0; lat++; end
        prog_we = 1'b0;
        instr = rsp_instr;
        fault = rsp_fault;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] instr;
        logic        fault;
        int          lat, n, na, nr;
        logic        seen, upd;
        int          at [2];
        int          rt [2];
        logic [31:0] ri [2];

        reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
        prog_we = 1'b0; prog_addr = 32'h0; prog_wdata = 32'h0;
        w0_req_valid = 1'b0; w0_req_addr = 32'h0; w0_rsp_ready = 1'b1;

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h0,          32'h0050_0093, 1'b0};
        vecs[1]  = '{32'h0000_0004, 1'b0, 32'h0,          32'h00A0_0113, 1'b0};
        vecs[2]  = '{32'h0000_0008, 1'b0, 32'h0,          32'h0020_81B3, 1'b0};
        vecs[3]  = '{32'h0000_000C, 1'b1, 32'h2222_2222,  32'h0000_006F, 1'b0};
        vecs[4]  = '{32'h0000_000C, 1'b0, 32'h0,          32'h2222_2222, 1'b0};
        vecs[5]  = '{32'h0000_0400, 1'b0, 32'h0,          32'h0000_0013, 1'b1};
        vecs[6]  = '{32'h0000_0004, 1'b0, 32'h0,          32'h00A0_0113, 1'b0};
        vecs[7]  = '{32'h0000_03FC, 1'b0, 32'h0,          32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 32'h0,          32'h0000_0013, 1'b1};
        vecs[9]  = '{32'h0001_0000, 1'b0, 32'h0,          32'h0000_0013, 1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
        vecs[10] = '{32'h0000_0006, 1'b0, 32'h0,          32'h0000_0013, 1'b1};
`else
        vecs[10] = '{32'h0000_0006, 1'b0, 32'h0,          32'h00A0_0113, 1'b0};
`endif

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_w0_req_ready", 32'(w0_req_ready), 32'd1);
        check("rst_w0_rsp_valid", 32'(w0_rsp_valid), 32'd0);
        reset = 1'b0;

        prog_write(32'h0000_0000, 32'h0050_0093);
        prog_write(32'h0000_0004, 32'h00A0_0113);
        prog_write(32'h0000_0008, 32'h0020_81B3);
        prog_write(32'h0000_000C, 32'h0000_006F);
        prog_write(32'h0000_03FC, 32'hDEAD_BEEF);
        prog_write(32'h0000_0400, 32'hBAD0_BAD0);
        prog_write(32'h0001_0000, 32'hBAD1_BAD1);

        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i].addr, vecs[i].wr, vecs[i].wdata, instr, fault, lat);
            check($sformatf("vec%0d_instr", i), instr, vecs[i].instr);
            check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].fault));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAITC + 1));
        end

        // Backpressure with a write to the held word.
        @(negedge clk);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_instr", k), rsp_instr, 32'h0020_81B3);
            check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
            if (k == 1) begin prog_we = 1'b1; prog_addr = 32'h8; prog_wdata = 32'h1111_1111; end
            @(negedge clk);
            prog_we = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_ready", 32'(req_ready), 32'd1);
        fetch(32'h8, 1'b0, 32'h0, instr, fault, lat);
        check("bp_new_word", instr, 32'h1111_1111);

        // Reset in the middle of WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_ready_low", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_async_ready", 32'(req_ready), 32'd1);
        check("rst_async_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        check("rst_no_rsp", 32'(seen), 32'd0);
        check("rst_release_ready", 32'(req_ready), 32'd1);
        fetch(32'h4, 1'b0, 32'h0, instr, fault, lat);
        check("rst_mem_intact", instr, 32'h00A0_0113);
        check("rst_mem_fault", 32'(fault), 32'd0);

        // Zero-wait instance: back-to-back fetches at 0 and 4.
        na = 0; nr = 0; upd = 1'b0;
        at[0] = 0; at[1] = 0; rt[0] = 0; rt[1] = 0; ri[0] = 32'h0; ri[1] = 32'h0;
        @(negedge clk);
        w0_req_valid = 1'b1; w0_req_addr = 32'h0; w0_rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (upd) begin
                if (na == 1) w0_req_addr = 32'h4;
                else w0_req_valid = 1'b0;
                upd = 1'b0;
            end
            if (w0_rsp_valid && nr < 2) begin rt[nr] = k; ri[nr] = w0_rsp_instr; nr++; end
            if (w0_req_ready && w0_req_valid && na < 2) begin at[na] = k; na++; upd = 1'b1; end
            @(negedge clk);
        end
        check("w0_accepts", 32'(na), 32'd2);
        check("w0_responses", 32'(nr), 32'd2);
        check("w0_spacing", 32'(at[1] - at[0]), 32'd2);
        check("w0_lat0", 32'(rt[0] - at[0]), 32'd1);
        check("w0_lat1", 32'(rt[1] - at[1]), 32'd1);
        check("w0_instr0", ri[0], 32'h0050_0093);
        check("w0_instr1", ri[1], 32'h00A0_0113);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
